// File: rtl/lsu_controller_if.sv
// Execute/commit handshakes plus the AXI4-Lite control channels seen by the LSU control FSM.
interface lsu_controller_if;
   logic       valid_pre_i;
   logic       ready_pre_o;
   logic       mem_ren_i;
   logic       mem_wen_i;
   logic       valid_post_o;
   logic       ready_post_i;
   logic       we_o;
   logic       rdata_we_o;
   logic       arvalid_o;
   logic       arready_i;
   logic       rvalid_i;
   logic       rready_o;
   logic [1:0] rresp_i;
   logic       awvalid_o;
   logic       awready_i;
   logic       wvalid_o;
   logic       wready_i;
   logic       bvalid_i;
   logic       bready_o;
   logic [1:0] bresp_i;
   logic       err_o;
   logic [1:0] err_cause_o;

   modport master (
      input  valid_pre_i, mem_ren_i, mem_wen_i, ready_post_i,
      input  arready_i, rvalid_i, rresp_i, awready_i, wready_i, bvalid_i, bresp_i,
      output ready_pre_o, valid_post_o, we_o, rdata_we_o,
      output arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, err_o, err_cause_o
   );

   modport slave (
      output valid_pre_i, mem_ren_i, mem_wen_i, ready_post_i,
      output arready_i, rvalid_i, rresp_i, awready_i, wready_i, bvalid_i, bresp_i,
      input  ready_pre_o, valid_post_o, we_o, rdata_we_o,
      input  arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, err_o, err_cause_o
   );
endinterface

// File: rtl/lsu_controller.sv
// Memory-stage control FSM: one AXI4-Lite read/write per instruction, 1-cycle pass-through, 3-cycle load/store.
// Accepts only when idle; holds the finished instruction and its error status until commit is ready.
module lsu_controller #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input logic              clock,
   input logic              reset,
   lsu_controller_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t           state, state_nxt;
   logic             aw_done, aw_done_nxt;
   logic             w_done, w_done_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             err, err_nxt;
   logic [1:0]       err_cause, err_cause_nxt;
   logic             expired;

   assign expired         = (TIMEOUT > 0) && (cnt == CNT_LAST);
   assign bus.err_o       = err;
   assign bus.err_cause_o = err_cause;

   always_comb begin
      state_nxt        = state;
      aw_done_nxt      = aw_done;
      w_done_nxt       = w_done;
      cnt_nxt          = cnt;
      err_nxt          = err;
      err_cause_nxt    = err_cause;
      bus.ready_pre_o  = 1'b0;
      bus.we_o         = 1'b0;
      bus.valid_post_o = 1'b0;
      bus.rdata_we_o   = 1'b0;
      bus.arvalid_o    = 1'b0;
      bus.rready_o     = 1'b0;
      bus.awvalid_o    = 1'b0;
      bus.wvalid_o     = 1'b0;
      bus.bready_o     = 1'b0;

      if (state inside {S_AR, S_R, S_WR, S_B}) begin
         cnt_nxt = cnt + 1'b1;
      end

      case (state)
         S_IDLE: begin
            bus.ready_pre_o = 1'b1;
            bus.we_o        = bus.valid_pre_i;
            if (bus.valid_pre_i) begin
               err_nxt       = 1'b0;
               err_cause_nxt = 2'b00;
               cnt_nxt       = '0;
               if (bus.mem_wen_i)      state_nxt = S_WR;
               else if (bus.mem_ren_i) state_nxt = S_AR;
               else                    state_nxt = S_DONE;
            end
         end
         S_AR: begin
            bus.arvalid_o = 1'b1;
            if (bus.arready_i) begin
               state_nxt = S_R;
            end else if (expired) begin
               state_nxt     = S_DONE;
               err_nxt       = 1'b1;
               err_cause_nxt = 2'b10;
            end
         end
         S_R: begin
            bus.rready_o   = 1'b1;
            bus.rdata_we_o = bus.rvalid_i;
            if (bus.rvalid_i) begin
               state_nxt = S_DONE;
               if (bus.rresp_i != 2'b00) begin
                  err_nxt       = 1'b1;
                  err_cause_nxt = 2'b01;
               end
            end else if (expired) begin
               state_nxt     = S_DONE;
               err_nxt       = 1'b1;
               err_cause_nxt = 2'b10;
            end
         end
         S_WR: begin
            bus.awvalid_o = ~aw_done;
            bus.wvalid_o  = ~w_done;
            // A handshake only fires while its valid is up, so OR-ing ready in is the handshake.
            aw_done_nxt   = aw_done | bus.awready_i;
            w_done_nxt    = w_done | bus.wready_i;
            if (aw_done_nxt && w_done_nxt) begin
               state_nxt   = S_B;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end else if (expired) begin
               state_nxt     = S_DONE;
               err_nxt       = 1'b1;
               err_cause_nxt = 2'b10;
               aw_done_nxt   = 1'b0;
               w_done_nxt    = 1'b0;
            end
         end
         S_B: begin
            bus.bready_o = 1'b1;
            if (bus.bvalid_i) begin
               state_nxt = S_DONE;
               if (bus.bresp_i != 2'b00) begin
                  err_nxt       = 1'b1;
                  err_cause_nxt = 2'b01;
               end
            end else if (expired) begin
               state_nxt     = S_DONE;
               err_nxt       = 1'b1;
               err_cause_nxt = 2'b10;
            end
         end
         S_DONE: begin
            bus.valid_post_o = 1'b1;
            if (bus.ready_post_i) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         cnt       <= '0;
         err       <= 1'b0;
         err_cause <= 2'b00;
      end else begin
         state     <= state_nxt;
         aw_done   <= aw_done_nxt;
         w_done    <= w_done_nxt;
         cnt       <= cnt_nxt;
         err       <= err_nxt;
         err_cause <= err_cause_nxt;
      end
   end
endmodule

// File: tb/tb_lsu_controller.sv
// Directed and randomized transactions checked cycle by cycle against a timeline model of each instruction.
module tb_lsu_controller;
   localparam int TMO = 8;

   logic clock = 1'b0;
   logic reset;
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;
   int   txn    = 0;
   int   cur_t  = 0;

   lsu_controller_if bus_if ();

   lsu_controller #(.TIMEOUT(TMO), .CNT_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s txn=%0d t=%0d observed=%0b expected=%0b", tag, txn, cur_t, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s txn=%0d t=%0d observed=%0b expected=%0b", tag, txn, cur_t, obs, exp);
      end
   endtask

   task automatic drive_quiet();
      bus_if.valid_pre_i  = 1'b0;
      bus_if.mem_ren_i    = 1'b0;
      bus_if.mem_wen_i    = 1'b0;
      bus_if.ready_post_i = 1'b0;
      bus_if.arready_i    = 1'b0;
      bus_if.rvalid_i     = 1'b0;
      bus_if.rresp_i      = 2'b00;
      bus_if.awready_i    = 1'b0;
      bus_if.wready_i     = 1'b0;
      bus_if.bvalid_i     = 1'b0;
      bus_if.bresp_i      = 2'b00;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // kind: 0 pass-through, 1 load, 2 store. Load: d1 = AR wait, d2 = R wait.
   // Store: d1 = AW wait, d2 = W wait, d3 = B wait after both are done. post_dly = commit stall cycles.
   task automatic run_txn(input int kind, input int d1, input int d2, input int d3,
                          input logic [1:0] resp, input int post_dly);
      int         m, n, k_last, t_done, t_end;
      bit         tmo;
      logic       exp_err;
      logic [1:0] exp_cause;
      m = (d1 > d2) ? d1 : d2;
      case (kind)
         1:       n = d1 + d2 + 2;
         2:       n = m + d3 + 2;
         default: n = 0;
      endcase
      tmo       = (n > TMO);
      k_last    = tmo ? TMO - 1 : n - 1;
      t_done    = (kind == 0) ? 1 : k_last + 2;
      t_end     = t_done + post_dly;
      exp_err   = tmo || (kind != 0 && resp != 2'b00);
      exp_cause = tmo ? 2'b10 : (exp_err ? 2'b01 : 2'b00);
      txn       = txn + 1;

      for (int t = 0; t <= t_end + 1; t++) begin
         int   k;
         bit   act;
         logic in_done;
         k       = t - 1;
         cur_t   = t;
         act     = (kind != 0) && (t >= 1) && (k <= k_last);
         in_done = (t >= t_done) && (t <= t_end);

         if (t == 0) begin
            bus_if.valid_pre_i = 1'b1;
            bus_if.mem_wen_i   = (kind == 2);
            bus_if.mem_ren_i   = (kind == 1) || (kind == 2 && 1'($urandom));
         end else if (t <= t_end) begin
            bus_if.valid_pre_i = 1'($urandom);
            bus_if.mem_wen_i   = 1'($urandom);
            bus_if.mem_ren_i   = 1'($urandom);
         end else begin
            bus_if.valid_pre_i = 1'b0;
            bus_if.mem_wen_i   = 1'b0;
            bus_if.mem_ren_i   = 1'b0;
         end
         bus_if.ready_post_i = in_done ? (t == t_end) : 1'($urandom);
         bus_if.arready_i    = (kind == 1) && (k == d1);
         bus_if.rvalid_i     = (kind == 1) && (k == n - 1);
         bus_if.rresp_i      = bus_if.rvalid_i ? resp : 2'($urandom);
         bus_if.awready_i    = (kind == 2) && (k == d1);
         bus_if.wready_i     = (kind == 2) && (k == d2);
         bus_if.bvalid_i     = (kind == 2) && (k == m + 1 + d3);
         bus_if.bresp_i      = bus_if.bvalid_i ? resp : 2'($urandom);
         #2;

         chk1("ready_pre",  bus_if.ready_pre_o,  (t == 0) || (t > t_end));
         chk1("we",         bus_if.we_o,         t == 0);
         chk1("valid_post", bus_if.valid_post_o, in_done);
         chk1("arvalid",    bus_if.arvalid_o,    (kind == 1) && act && (k <= d1));
         chk1("rready",     bus_if.rready_o,     (kind == 1) && act && (k > d1));
         chk1("rdata_we",   bus_if.rdata_we_o,   (kind == 1) && act && (k > d1) && (k == n - 1));
         chk1("awvalid",    bus_if.awvalid_o,    (kind == 2) && act && (k <= d1));
         chk1("wvalid",     bus_if.wvalid_o,     (kind == 2) && act && (k <= d2));
         chk1("bready",     bus_if.bready_o,     (kind == 2) && act && (k > m));
         if (in_done) begin
            chk1("err",       bus_if.err_o,       exp_err);
            chk2("err_cause", bus_if.err_cause_o, exp_cause);
         end
         step();
      end
   endtask

   initial begin
      drive_quiet();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      #2;
      chk1("rst_ready_pre",  bus_if.ready_pre_o,  1'b1);
      chk1("rst_valid_post", bus_if.valid_post_o, 1'b0);
      chk1("rst_arvalid",    bus_if.arvalid_o,    1'b0);
      chk1("rst_awvalid",    bus_if.awvalid_o,    1'b0);
      chk1("rst_wvalid",     bus_if.wvalid_o,     1'b0);
      chk1("rst_rready",     bus_if.rready_o,     1'b0);
      chk1("rst_bready",     bus_if.bready_o,     1'b0);
      chk1("rst_err",        bus_if.err_o,        1'b0);
      chk2("rst_err_cause",  bus_if.err_cause_o,  2'b00);
      reset = 1'b1;
      step();

      run_txn(0, 0, 0, 0, 2'b00, 0);   // ALU pass-through
      run_txn(1, 2, 3, 0, 2'b00, 0);   // load, AR waits 2, R waits 3
      run_txn(2, 2, 0, 0, 2'b10, 0);   // store, W two cycles before AW, error response
      run_txn(1, 20, 0, 0, 2'b00, 0);  // AR never answered: timeout
      run_txn(1, 0, 0, 0, 2'b01, 3);   // commit stalls 3 cycles with error held
      run_txn(1, 3, 3, 0, 2'b00, 0);   // R completes on the last watchdog cycle
      run_txn(1, 3, 4, 0, 2'b00, 0);   // one cycle too late: timeout in R
      run_txn(2, 3, 3, 3, 2'b00, 0);   // B completes on the last watchdog cycle
      run_txn(2, 9, 1, 0, 2'b00, 1);   // AW never in time: timeout in WR
      run_txn(2, 1, 1, 0, 2'b11, 0);   // AW and W in the same cycle
      run_txn(2, 0, 0, 0, 2'b00, 0);   // zero-wait store
      run_txn(0, 0, 0, 0, 2'b00, 2);   // pass-through with commit stall

      // Reset during R abandons the read and returns to idle.
      txn   = txn + 1;
      cur_t = 0;
      bus_if.valid_pre_i = 1'b1;
      bus_if.mem_ren_i   = 1'b1;
      step();
      drive_quiet();
      bus_if.arready_i = 1'b1;
      #2;
      chk1("mrst_arvalid", bus_if.arvalid_o, 1'b1);
      step();
      drive_quiet();
      #2;
      chk1("mrst_rready_before", bus_if.rready_o, 1'b1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      #2;
      chk1("mrst_rready",     bus_if.rready_o,     1'b0);
      chk1("mrst_arvalid_lo", bus_if.arvalid_o,    1'b0);
      chk1("mrst_valid_post", bus_if.valid_post_o, 1'b0);
      chk1("mrst_ready_pre",  bus_if.ready_pre_o,  1'b1);
      step();

      for (int i = 0; i < 60; i++) begin
         run_txn($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 4), 2'($urandom), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
Control FSM of the memory-access stage, directly upstream of the commit stage. Accepts one instruction at a time from execute, sequences an AXI4-Lite read or write on the data bus, and hands the finished instruction to commit. Datapath registers (address, wdata, rdata) live in the LSU datapath; this block only drives their enables and the bus handshakes. Non-memory instructions pass straight through.

Parameters:
TIMEOUT, 255, bus-wait cycles before abort; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
valid_pre_i  in  1  execute has an instruction
ready_pre_o  out  1  stage can accept
mem_ren_i  in  1  instruction is a load (sampled with valid_pre_i)
mem_wen_i  in  1  instruction is a store (sampled with valid_pre_i)
valid_post_o  out  1  instruction ready for commit
ready_post_i  in  1  commit can accept
we_o  out  1  latch enable for stage input registers
rdata_we_o  out  1  latch enable for read-data register
arvalid_o  out  1  AR valid
arready_i  in  1  AR ready
rvalid_i  in  1  R valid
rready_o  out  1  R ready
rresp_i  in  2  R response
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bvalid_i  in  1  B valid
bready_o  out  1  B ready
bresp_i  in  2  B response
err_o  out  1  instruction finished with error; meaningful only while valid_post_o
err_cause_o  out  2  01 bus error, 10 timeout, 00 none

Behaviour:
- States: IDLE, AR, R, WR, B, DONE. Reset -> IDLE, aw_done=w_done=0, counter=0, err_o=0, err_cause_o=00. All valid/ready outputs low except ready_pre_o=1.
- ready_pre_o = (state==IDLE). we_o = valid_pre_i & ready_pre_o. valid_post_o = (state==DONE).
- IDLE: on valid_pre_i, mem_wen_i=1 -> WR (wen has priority over ren); mem_ren_i=1 -> AR; neither -> DONE. Clear err_o/err_cause_o and counter on the accept.
- AR: arvalid_o=1. When arready_i -> R.
- R: rready_o=1. rdata_we_o = rvalid_i & rready_o. When rvalid_i -> DONE; rresp_i!=00 sets err_o=1, cause 01.
- WR: awvalid_o = ~aw_done, wvalid_o = ~w_done. The aw_done and w_done flags set independently on their handshakes, in either order or the same cycle. Go to B in the cycle both handshakes are complete, counting a handshake completed that cycle. Clear both flags on leaving WR.
- B: bready_o=1. When bvalid_i -> DONE; bresp_i!=00 sets err_o=1, cause 01.
- DONE: hold valid_post_o, err_o, and err_cause_o stable until ready_post_i. Then -> IDLE.
- Latency with zero-wait bus and ready_post_i=1: pass-through accept->valid_post 1 cycle. Load 3 cycles (AR, R, DONE). Store 3 cycles (WR, B, DONE).
- Watchdog (TIMEOUT>0): counter increments each cycle in AR/R/WR/B and resets to 0 on entering AR or WR. If a cycle in AR/R/WR/B has counter==TIMEOUT-1 and that state's completing handshake is absent, go to DONE with err_o=1, cause 10. Drop all bus valid/ready outputs on that transition; rdata_we_o must not fire.
- Completing handshake and timeout in the same cycle: the handshake wins.
- Reset mid-transaction: next edge returns to IDLE with all bus outputs low. The outstanding bus beat is abandoned; the bus is reset together with the core.
- No new instruction is accepted while busy. Back-to-back throughput is one instruction per (latency+1) cycles.

Test Plan:
- ALU pass-through: valid_pre_i=1, ren=wen=0 at cycle 0 -> we_o=1 at cycle 0; valid_post_o=1 at cycle 1; ready_pre_o=1 at cycle 2. No bus activity.
- Load with arready delayed 2 and rvalid delayed 3, rresp=00 -> arvalid high 3 cycles; rready high until rvalid; rdata_we_o single pulse; valid_post_o the next cycle with err_o=0.
- Store with wready 2 cycles before awready -> wvalid drops after its handshake while awvalid stays high. B entered only after AW; bresp=10 -> err_o=1, err_cause_o=01.
- Timeout, TIMEOUT=8, arready held 0 -> arvalid drops after 8 cycles; valid_post_o=1, err_cause_o=10; rdata_we_o never fires.
- Backpressure: ready_post_i=0 for 3 cycles in DONE -> valid_post_o and err_o stable; ready_pre_o stays 0; IDLE after ready_post_i=1.
- Reset=0 asserted during R state -> next cycle IDLE, rready_o=0, valid_post_o=0, ready_pre_o=1.
